// File: rtl/raw_hazard_scheduler_pkg.sv
// Shared types and defaults for the decode-stage RAW hazard scheduler.
// The slot entry mirrors the destination info of one in-flight pipeline register.
package raw_hazard_scheduler_pkg;

    localparam int RHS_REG_BITS = 3;
    localparam int RHS_DEPTH    = 3;

    typedef struct packed {
        logic                    valid;
        logic                    wr;
        logic [RHS_REG_BITS-1:0] dest;
    } slot_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_e;

endpackage

// File: rtl/raw_hazard_scheduler_if.sv
// Decode-stage <-> scheduler signal bundle: ID instruction info in, pipeline
// enables and status out. The decode side is the master.
interface raw_hazard_scheduler_if
    import raw_hazard_scheduler_pkg::*;
#(
    parameter int REG_BITS = RHS_REG_BITS
) ();

    logic                id_valid;
    logic [REG_BITS-1:0] id_rs;
    logic [REG_BITS-1:0] id_rt;
    logic                id_rs_used;
    logic                id_rt_used;
    logic                id_reg_write;
    logic [REG_BITS-1:0] id_rd;
    logic                id_halt;
    logic                id_illegal;
    logic                flush;

    logic                stall;
    logic                pc_write_en;
    logic                if_id_write_en;
    logic                id_ex_bubble;
    logic                halt_done;
    logic                err;

    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
               id_reg_write, id_rd, id_halt, id_illegal, flush,
        input  stall, pc_write_en, if_id_write_en, id_ex_bubble,
               halt_done, err
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
               id_reg_write, id_rd, id_halt, id_illegal, flush,
        output stall, pc_write_en, if_id_write_en, id_ex_bubble,
               halt_done, err
    );

endinterface

// File: rtl/raw_hazard_scheduler_scoreboard_match.sv
// Flags a source register that is still pending write-back in any in-flight slot.
// A slot retiring this cycle still counts; the register file sees it next cycle.
module scoreboard_match
    import raw_hazard_scheduler_pkg::*;
#(
    parameter int DEPTH    = RHS_DEPTH,
    parameter int REG_BITS = RHS_REG_BITS
) (
    input  slot_t [DEPTH-1:0]   slots_i,
    input  logic [REG_BITS-1:0] src_i,
    input  logic                used_i,
    output logic                hit_o
);

    logic any_hit;

    always_comb begin
        any_hit = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (slots_i[k].valid && slots_i[k].wr && (slots_i[k].dest == src_i)) begin
                any_hit = 1'b1;
            end
        end
        hit_o = any_hit & used_i;
    end

endmodule

// File: rtl/raw_hazard_scheduler.sv
// Decode-stage issue scheduler: stalls on RAW hazards (no forwarding), kills on
// flush, and sequences HALT through a drain period before reporting completion.
module raw_hazard_scheduler
    import raw_hazard_scheduler_pkg::*;
#(
    parameter int DEPTH    = RHS_DEPTH,
    parameter int REG_BITS = RHS_REG_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    raw_hazard_scheduler_if.slave  dec_if
);

    localparam int               CNT_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

    localparam logic [1:0] S_RUN    = RUN;
    localparam logic [1:0] S_DRAIN  = DRAIN;
    localparam logic [1:0] S_HALTED = HALTED;

    slot_t [DEPTH-1:0] slot_q, slot_d;
    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    logic hit_rs, hit_rt;
    logic in_run, hazard, issue;

    scoreboard_match #(.DEPTH(DEPTH), .REG_BITS(REG_BITS)) u_match_rs (
        .slots_i (slot_q),
        .src_i   (dec_if.id_rs),
        .used_i  (dec_if.id_rs_used),
        .hit_o   (hit_rs)
    );

    scoreboard_match #(.DEPTH(DEPTH), .REG_BITS(REG_BITS)) u_match_rt (
        .slots_i (slot_q),
        .src_i   (dec_if.id_rt),
        .used_i  (dec_if.id_rt_used),
        .hit_o   (hit_rt)
    );

    always_comb begin
        in_run = (state_q == S_RUN);
        hazard = dec_if.id_valid & in_run & (hit_rs | hit_rt);
        issue  = dec_if.id_valid & ~hazard & ~dec_if.flush & in_run;

        // Slot 0 is the ID/EX register; a non-issue cycle loads a bubble.
        slot_d[0] = issue ? slot_t'{valid: 1'b1, wr: dec_if.id_reg_write, dest: dec_if.id_rd}
                          : slot_t'('0);
        for (int k = 1; k < DEPTH; k++) begin
            slot_d[k] = slot_q[k-1];
        end

        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_RUN: begin
                cnt_d = '0;
                if (issue && dec_if.id_halt) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_HALTED;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_RUN;
        endcase

        err_d = issue & dec_if.id_illegal;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q  <= '0;
            state_q <= S_RUN;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Reset forces the pipeline to hold with bubbles regardless of state.
    assign dec_if.stall          = ~rst & hazard;
    assign dec_if.pc_write_en    = ~rst & in_run & (~hazard | dec_if.flush);
    assign dec_if.if_id_write_en = ~rst & in_run & (~hazard | dec_if.flush);
    assign dec_if.id_ex_bubble   = rst | ~issue;
    assign dec_if.halt_done      = ~rst & (state_q == S_HALTED);
    assign dec_if.err            = err_q;

endmodule

// File: tb/tb_raw_hazard_scheduler.sv
// Directed bench for raw_hazard_scheduler: expected per-cycle outputs are queued
// with each stimulus cycle and popped for comparison mid-cycle.
module tb_raw_hazard_scheduler;
    import raw_hazard_scheduler_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    raw_hazard_scheduler_if bus ();

    raw_hazard_scheduler dut (
        .clk    (clk),
        .rst    (rst),
        .dec_if (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Expected output vector: {stall, pc_we, if_id_we, bubble, halt_done, err}
    logic [5:0] exp_q[$];

    localparam logic [5:0] E_RST     = 6'b000100;
    localparam logic [5:0] E_ISSUE   = 6'b011000;
    localparam logic [5:0] E_STALL   = 6'b100100;
    localparam logic [5:0] E_IDLE    = 6'b011100;
    localparam logic [5:0] E_IDLEERR = 6'b011101;
    localparam logic [5:0] E_FLSTALL = 6'b111100;
    localparam logic [5:0] E_DRAIN   = 6'b000100;
    localparam logic [5:0] E_HALTED  = 6'b000110;

    task automatic check_eq(input string tag, input logic got, input logic exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", tag, got, exp);
    endtask

    task automatic drv(input logic v, input logic [2:0] rs, input logic [2:0] rt,
                       input logic rsu, input logic rtu, input logic rw,
                       input logic [2:0] rd, input logic halt, input logic ill,
                       input logic fl);
        bus.id_valid     = v;
        bus.id_rs        = rs;
        bus.id_rt        = rt;
        bus.id_rs_used   = rsu;
        bus.id_rt_used   = rtu;
        bus.id_reg_write = rw;
        bus.id_rd        = rd;
        bus.id_halt      = halt;
        bus.id_illegal   = ill;
        bus.flush        = fl;
    endtask

    task automatic idle();
        drv(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic cyc(input string tag, input logic [5:0] e);
        logic [5:0] x;
        exp_q.push_back(e);
        @(negedge clk);
        x = exp_q.pop_front();
        check_eq({tag, ".stall"},  bus.stall,          x[5]);
        check_eq({tag, ".pc_we"},  bus.pc_write_en,    x[4]);
        check_eq({tag, ".ifid_we"}, bus.if_id_write_en, x[3]);
        check_eq({tag, ".bubble"}, bus.id_ex_bubble,   x[2]);
        check_eq({tag, ".hdone"},  bus.halt_done,      x[1]);
        check_eq({tag, ".err"},    bus.err,            x[0]);
        @(posedge clk);
        #1;
    endtask

    task automatic producer(input logic [2:0] rd);
        drv(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, rd, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        drv(1'b1, 3'd1, 3'd1, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        cyc("reset", E_RST);
        rst = 1'b0;

        // back-to-back producer/consumer on r1
        producer(3'd1);
        cyc("t1_prod", E_ISSUE);
        drv(1'b1, 3'd1, 3'd3, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
        repeat (3) cyc("t1_stall", E_STALL);
        cyc("t1_issue", E_ISSUE);
        idle();
        repeat (3) cyc("t1_drain", E_IDLE);

        // one independent instruction between producer and rt consumer
        producer(3'd4);
        cyc("t2_prod", E_ISSUE);
        drv(1'b1, 3'd6, 3'd0, 1'b1, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
        cyc("t2_indep", E_ISSUE);
        drv(1'b1, 3'd0, 3'd4, 1'b0, 1'b1, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0);
        repeat (2) cyc("t2_stall", E_STALL);
        cyc("t2_issue", E_ISSUE);
        idle();
        repeat (3) cyc("t2_drain", E_IDLE);

        // same sequence, rt not read
        producer(3'd4);
        cyc("t2b_prod", E_ISSUE);
        drv(1'b1, 3'd6, 3'd0, 1'b1, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
        cyc("t2b_indep", E_ISSUE);
        drv(1'b1, 3'd0, 3'd4, 1'b0, 1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0);
        cyc("t2b_nouse", E_ISSUE);
        idle();
        repeat (3) cyc("t2b_drain", E_IDLE);

        // flush while the consumer is stalled
        producer(3'd1);
        cyc("t3_prod", E_ISSUE);
        drv(1'b1, 3'd1, 3'd0, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1);
        cyc("t3_flush", E_FLSTALL);
        drv(1'b1, 3'd2, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        cyc("t3_killed_gone", E_ISSUE);
        idle();
        repeat (3) cyc("t3_drain", E_IDLE);

        // illegal instruction stalled, then issued
        producer(3'd1);
        cyc("t4_prod", E_ISSUE);
        drv(1'b1, 3'd1, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        repeat (3) cyc("t4_ill_stall", E_STALL);
        cyc("t4_ill_issue", E_ISSUE);
        idle();
        cyc("t4_err_pulse", E_IDLEERR);
        repeat (2) cyc("t4_err_clear", E_IDLE);

        // illegal instruction flushed on its would-be issue cycle
        producer(3'd1);
        cyc("t4b_prod", E_ISSUE);
        drv(1'b1, 3'd1, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        repeat (3) cyc("t4b_ill_stall", E_STALL);
        drv(1'b1, 3'd1, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
        cyc("t4b_ill_flush", E_IDLE);
        idle();
        repeat (3) cyc("t4b_no_err", E_IDLE);

        // HALT with two writers in flight
        producer(3'd1);
        cyc("t5_w1", E_ISSUE);
        producer(3'd2);
        cyc("t5_w2", E_ISSUE);
        drv(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
        cyc("t5_halt", E_ISSUE);
        drv(1'b1, 3'd1, 3'd2, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
        repeat (3) cyc("t5_drain", E_DRAIN);
        cyc("t5_halted", E_HALTED);
        drv(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1);
        cyc("t5_flush_ignored", E_HALTED);
        idle();
        cyc("t5_sticky", E_HALTED);

        // reset out of HALTED, then reset in DRAIN clears in-flight slots
        rst = 1'b1;
        cyc("t6_rst_halted", E_RST);
        rst = 1'b0;
        producer(3'd3);
        cyc("t6_w3", E_ISSUE);
        drv(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
        cyc("t6_halt", E_ISSUE);
        idle();
        rst = 1'b1;
        cyc("t6_rst_drain", E_RST);
        rst = 1'b0;
        drv(1'b1, 3'd3, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        cyc("t6_slots_empty", E_ISSUE);
        idle();
        repeat (3) cyc("t6_drain", E_IDLE);
        producer(3'd1);
        cyc("t6_prod", E_ISSUE);
        drv(1'b1, 3'd1, 3'd0, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
        repeat (3) cyc("t6_stall", E_STALL);
        cyc("t6_issue", E_ISSUE);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
